// File: rtl/dcm_prog_responder_pkg.sv
// Shared definitions for the DCM_CLKGEN programming-port responder:
// command codes, frame lengths, FSM encoding and the load-value decoder.
package dcm_prog_responder_pkg;

  // Command bits in arrival order: bits[1:0] = {bit1, bit0}
  localparam logic [1:0] CMD_LOADD      = 2'b01;
  localparam logic [1:0] CMD_LOADM      = 2'b11;
  localparam logic [3:0] LOAD_FRAME_LEN = 4'd10;
  localparam logic [3:0] GO_FRAME_LEN   = 4'd1;
  localparam logic [3:0] FRAME_LEN_SAT  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  // Load frames carry value-1 in bits[9:2], LSB first
  function automatic logic [8:0] decode_value(input logic [9:0] bits);
    return {1'b0, bits[9:2]} + 9'd1;
  endfunction

endpackage

// File: rtl/dcm_prog_responder_if.sv
// Serial DCM programming link: the initiator drives en/data, the responder drives done.
interface dcm_prog_responder_if;
  logic dcm_prog_en;
  logic dcm_prog_data;
  logic dcm_prog_done;

  modport master (output dcm_prog_en, output dcm_prog_data, input dcm_prog_done);
  modport slave  (input dcm_prog_en, input dcm_prog_data, output dcm_prog_done);
endinterface

// File: rtl/dcm_prog_responder_frame_rx.sv
// Frame deserialiser: captures the first ten bits of an en-high run and its
// saturating length, and strobes frame_valid on the first en-low cycle.
module dcm_prog_responder_frame_rx
  import dcm_prog_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       data,
  output logic       frame_valid,
  output logic [3:0] frame_len,
  output logic [9:0] frame_bits
);

  logic [3:0] len_reg;
  logic [9:0] bits_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_reg  <= 4'd0;
      bits_reg <= 10'd0;
    end else if (en) begin
      for (int i = 0; i < 10; i++) begin
        if (len_reg == 4'(i)) bits_reg[i] <= data;
      end
      if (len_reg != FRAME_LEN_SAT) len_reg <= len_reg + 4'd1;
    end else begin
      len_reg <= 4'd0;
    end
  end

  // Valid while en is low and a run was just seen; parent samples it at this edge
  assign frame_valid = !en && (len_reg != 4'd0);
  assign frame_len   = len_reg;
  assign frame_bits  = bits_reg;

endmodule

// File: rtl/dcm_prog_responder.sv
// DCM_CLKGEN programming-port responder: decodes LoadD/LoadM/GO frames,
// applies new M/D after a relock latency and flags protocol violations.
module dcm_prog_responder
  import dcm_prog_responder_pkg::*;
#(
  parameter int INITIAL_MULTIPLIER = 60,
  parameter int INITIAL_DIVIDER    = 8,
  parameter int GO_LATENCY         = 16,
  parameter int MAXIMUM_MULTIPLIER = 88
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dcm_prog_responder_if.slave   prog,
  output logic [8:0]            multiplier,
  output logic [8:0]            divider,
  output logic                  apply_pulse,
  output logic                  proto_err
);

  logic       frame_valid;
  logic [3:0] frame_len;
  logic [9:0] frame_bits;

  state_t      state_reg;
  logic [15:0] cnt_reg;
  logic [8:0]  staged_m_reg;
  logic [8:0]  staged_d_reg;
  logic [8:0]  active_m_reg;
  logic [8:0]  active_d_reg;
  logic        done_reg;
  logic        apply_pulse_reg;
  logic        proto_err_reg;
  logic        staged_bad;

  dcm_prog_responder_frame_rx u_frame_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (prog.dcm_prog_en),
    .data        (prog.dcm_prog_data),
    .frame_valid (frame_valid),
    .frame_len   (frame_len),
    .frame_bits  (frame_bits)
  );

  assign staged_bad = (staged_m_reg < 9'd2) ||
                      (staged_m_reg > 9'(MAXIMUM_MULTIPLIER)) ||
                      (staged_d_reg == 9'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= 16'd0;
      staged_m_reg    <= 9'(INITIAL_MULTIPLIER);
      staged_d_reg    <= 9'(INITIAL_DIVIDER);
      active_m_reg    <= 9'(INITIAL_MULTIPLIER);
      active_d_reg    <= 9'(INITIAL_DIVIDER);
      done_reg        <= 1'b1;
      apply_pulse_reg <= 1'b0;
      proto_err_reg   <= 1'b0;
    end else begin
      apply_pulse_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (prog.dcm_prog_en) begin
            state_reg <= ST_RECV;
            done_reg  <= 1'b0;
          end
        end
        ST_RECV: begin
          if (frame_valid) begin
            if (frame_len == LOAD_FRAME_LEN && frame_bits[1:0] == CMD_LOADD) begin
              staged_d_reg <= decode_value(frame_bits);
            end else if (frame_len == LOAD_FRAME_LEN && frame_bits[1:0] == CMD_LOADM) begin
              staged_m_reg <= decode_value(frame_bits);
            end else if (frame_len == GO_FRAME_LEN && !frame_bits[0]) begin
              state_reg <= ST_APPLY;
              cnt_reg   <= 16'(GO_LATENCY - 1);
            end else begin
              proto_err_reg <= 1'b1;
            end
          end
        end
        ST_APPLY: begin
          // Traffic while relocking is illegal; frames ending here are dropped
          if (prog.dcm_prog_en) proto_err_reg <= 1'b1;
          if (cnt_reg == 16'd0) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b1;
            if (staged_bad) begin
              proto_err_reg <= 1'b1;
            end else begin
              active_m_reg    <= staged_m_reg;
              active_d_reg    <= staged_d_reg;
              apply_pulse_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign prog.dcm_prog_done = done_reg;
  assign multiplier         = active_m_reg;
  assign divider            = active_d_reg;
  assign apply_pulse        = apply_pulse_reg;
  assign proto_err          = proto_err_reg;

endmodule

// File: doc/dcm_prog_responder.md
Name: dcm_prog_responder

Overview:
- Far end of the DCM_CLKGEN serial dynamic-programming interface (prog_en / prog_data / prog_done).
- Deserialises LoadD, LoadM and GO frames, holds staged and active divider/multiplier values, and drives prog_done with a configurable relock latency.
- Used as the synthesisable clock-model stand-in in the miner simulation top, and as a protocol monitor beside the real DCM in debug builds.

Parameters:
- INITIAL_MULTIPLIER, 60, active M after reset (2..256).
- INITIAL_DIVIDER, 8, active D after reset (1..256).
- GO_LATENCY, 16, prog_clk cycles from end of the GO frame to prog_done rising (>=1).
- MAXIMUM_MULTIPLIER, 88, M above this is rejected at GO.

Ports:
- clk  in  1  DCM programming clock (same clock as the initiator's dcm_prog_clk).
- rst_n  in  1  synchronous reset, active low.
- dcm_prog_en  in  1  frame enable from the initiator.
- dcm_prog_data  in  1  serial data, sampled when dcm_prog_en=1, LSB first after the 2 command bits.
- dcm_prog_done  out  1  high = idle/locked; low from first frame of a sequence until the apply completes.
- multiplier  out  9  active M (actual value, not M-1).
- divider  out  9  active D (actual value, not D-1).
- apply_pulse  out  1  one-cycle strobe when new M/D become active.
- proto_err  out  1  sticky protocol-error flag; cleared only by reset.

Behaviour:
- Reset (rst_n=0 at a clk edge): dcm_prog_done=1, multiplier=INITIAL_MULTIPLIER, divider=INITIAL_DIVIDER, apply_pulse=0, proto_err=0, staged M/D = active values, FSM=IDLE, bit counter=0. A reset mid-frame or mid-apply abandons everything.
- Frame = maximal run of consecutive cycles with dcm_prog_en=1.
  - Bit 0 is the first sampled dcm_prog_data.
  - Bit counter saturates at 15.
  - The frame is classified on the first cycle en=0 after the run.
- Frame classification:
  - Length 10, bits[1:0]=(1,0): LoadD. staged_d <= bits[9:2] (LSB first) + 1.
  - Length 10, bits[1:0]=(1,1): LoadM. staged_m <= bits[9:2] + 1.
  - Length 1, bit0=0: GO.
  - Anything else, including length 10 with bit0=0: set proto_err, discard the frame, no state change.
- dcm_prog_done falls on the cycle after the first en=1 sample seen in IDLE. It is registered, so it is low from cycle 2 of the first frame.
- FSM states:
  - IDLE: done=1. en=1 -> RECV.
  - RECV: accumulate frames. A valid GO -> APPLY with counter=GO_LATENCY-1. LoadD/LoadM stay in RECV.
  - APPLY: count down. Any en=1 sample sets proto_err and is ignored. At counter=0 -> commit, apply_pulse=1, done=1 next cycle, -> IDLE.
- Commit rule: if staged_m < 2, staged_m > MAXIMUM_MULTIPLIER, or staged_d < 1, set proto_err, keep the old active values, and still raise done. No apply_pulse in that case.
- GO with no preceding Load frames re-applies the current staged values (relock only); apply_pulse still fires.
- Latency: last en=1 cycle of GO = cycle t; en=0 seen at t+1; done=1 and outputs updated at t+1+GO_LATENCY.
- Inter-frame gaps of any length (>=1 cycle) are legal in RECV. No timeout.

Decomposition:
- Shared package/header: command codes CMD_LOADD=2'b01 and CMD_LOADM=2'b11 (bit0 first), frame length constants LOAD_FRAME_LEN=10 and GO_FRAME_LEN=1, FSM state encodings.
- One sub-module, dcm_prog_frame_rx:
  - Function: en/data shift register plus length counter.
  - Outputs: frame_valid strobe, frame_len[3:0], frame_bits[9:0].
  - Parent holds the FSM, staged/active registers and the latency counter.

Test Plan:
- Reset -> done=1, multiplier=60, divider=8, proto_err=0.
- LoadD data 7, gap 3, LoadM data 59, gap 2, GO -> done low from LoadD cycle 2; at GO end +1+16 cycles done=1, multiplier=60, divider=8, one apply_pulse.
- Same sequence with LoadM data 71 -> multiplier=72, divider=8 after latency; then LoadM 99 (M=100>88) + GO -> proto_err=1, multiplier stays 72, done returns high, no apply_pulse.
- 9-bit frame (1,1 + 7 bits), then valid LoadM 40 + GO -> proto_err=1; multiplier=41 after latency.
- en pulse during APPLY -> proto_err=1; apply timing and values unchanged.
- rst_n=0 mid-LoadM (after 5 bits), release, send full LoadD 3/LoadM 30/GO -> first frame ignored; multiplier=31, divider=4.
